// File: rtl/veerwolf_pkg.sv
// -----------------------------------------------------------------------------
// veerwolf_pkg
// Shared constants for the VeeRwolf RAM initialiser: AXI4 encodings, the
// initialiser FSM state codes and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package veerwolf_pkg;

   // AXI4 encodings used by the initialiser
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

   // Initialiser FSM state codes
   localparam logic [2:0] ST_AW   = 3'd0;
   localparam logic [2:0] ST_W    = 3'd1;
   localparam logic [2:0] ST_B    = 3'd2;
   localparam logic [2:0] ST_RA   = 3'd3;
   localparam logic [2:0] ST_R    = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   // Width of a counter that must hold 0..n-1; never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n > 32'd1) begin
         return $clog2(n);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/veerwolf_ram_init_beatcnt.sv
// -----------------------------------------------------------------------------
// veerwolf_ram_init_beatcnt
// Beat counter within one AXI burst, shared by the write-data and read-data
// phases. Counts accepted beats and wraps to zero after the last one.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_adv     : a data beat was accepted this cycle
//   o_last    : the current beat is the last of the burst
// -----------------------------------------------------------------------------
module veerwolf_ram_init_beatcnt
   import veerwolf_pkg::*;
#(
   parameter int unsigned BURST_LEN = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_adv,
   output logic o_last
);

   localparam int CW = cnt_width(BURST_LEN);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 32'd1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);

   logic [CW-1:0] r_cnt;

   // Beat index: advances on each accepted beat, clears after the last beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= {CW{1'b0}};
      end else if (i_adv) begin
         if (r_cnt == LAST_BEAT) begin
            r_cnt <= {CW{1'b0}};
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_last = (r_cnt == LAST_BEAT);

endmodule

// File: rtl/veerwolf_ram_init.sv
// -----------------------------------------------------------------------------
// veerwolf_ram_init
// AXI4 write initiator that fills the on-chip RAM with FILL_VALUE after reset,
// one INCR burst at a time, then reports done/error to the core.
// Optional read-back verification is enabled with the macro
// VEERWOLF_RAM_INIT_VERIFY_EN (adds the AR/R ports).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   o_aw*, i_awready         : write address channel (constants + address)
//   o_w*, i_wready           : write data channel
//   i_bid, i_bresp, i_bvalid, o_bready : write response channel
//   o_ar*, i_arready, i_r*, o_rready   : read channels (verify build only)
//   o_init_done              : sticky, fill (and verify) complete
//   o_init_error             : sticky, any error response or data mismatch
// -----------------------------------------------------------------------------
module veerwolf_ram_init
   import veerwolf_pkg::*;
#(
   parameter int unsigned          ID_WIDTH   = 6,
   parameter int unsigned          ADDR_WIDTH = 16,
   parameter int unsigned          RAM_SIZE   = 32'h10000,
   parameter int unsigned          BURST_LEN  = 16,
   parameter logic [ID_WIDTH-1:0]  INIT_ID    = {ID_WIDTH{1'b0}},
   parameter logic [63:0]          FILL_VALUE = 64'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ID_WIDTH-1:0]   o_awid,
   output logic [ADDR_WIDTH-1:0] o_awaddr,
   output logic [7:0]            o_awlen,
   output logic [2:0]            o_awsize,
   output logic [1:0]            o_awburst,
   output logic                  o_awvalid,
   input  logic                  i_awready,
   output logic [63:0]           o_wdata,
   output logic [7:0]            o_wstrb,
   output logic                  o_wlast,
   output logic                  o_wvalid,
   input  logic                  i_wready,
   input  logic [ID_WIDTH-1:0]   i_bid,
   input  logic [1:0]            i_bresp,
   input  logic                  i_bvalid,
   output logic                  o_bready,
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
   output logic [ID_WIDTH-1:0]   o_arid,
   output logic [ADDR_WIDTH-1:0] o_araddr,
   output logic [7:0]            o_arlen,
   output logic [2:0]            o_arsize,
   output logic [1:0]            o_arburst,
   output logic                  o_arvalid,
   input  logic                  i_arready,
   input  logic [ID_WIDTH-1:0]   i_rid,
   input  logic [63:0]           i_rdata,
   input  logic [1:0]            i_rresp,
   input  logic                  i_rlast,
   input  logic                  i_rvalid,
   output logic                  o_rready,
`endif
   output logic                  o_init_done,
   output logic                  o_init_error
);

   localparam int unsigned NUM_BURSTS = RAM_SIZE / (BURST_LEN * 32'd8);
   localparam int          BW         = cnt_width(NUM_BURSTS);
   localparam logic [BW-1:0]         LAST_BURST  = BW'(NUM_BURSTS - 32'd1);
   localparam logic [BW-1:0]         BURST_ONE   = BW'(32'd1);
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 32'd8);
   localparam logic [7:0]            AXLEN       = 8'(BURST_LEN - 32'd1);
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
   localparam logic [2:0]            ST_AFTER_WR = ST_RA;
`else
   localparam logic [2:0]            ST_AFTER_WR = ST_DONE;
`endif

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [BW-1:0]         r_burst;
   logic                  r_done;
   logic                  r_error;
   logic                  w_last;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_rd_end;
   logic                  w_last_burst;
   logic                  w_beat_adv;
   logic                  w_err_evt;
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  w_ar_hs;
   logic                  w_r_hs;
`endif

   // Constant channel fields
   assign o_awid    = INIT_ID;
   assign o_awlen   = AXLEN;
   assign o_awsize  = AXI_SIZE_8B;
   assign o_awburst = AXI_BURST_INCR;
   assign o_wdata   = FILL_VALUE;
   assign o_wstrb   = 8'hFF;

   assign o_awaddr     = r_addr;
   assign o_awvalid    = r_awvalid;
   assign o_wvalid     = r_wvalid;
   assign o_wlast      = r_wvalid & w_last;
   assign o_bready     = r_bready;
   assign o_init_done  = r_done;
   assign o_init_error = r_error;

   assign w_aw_hs      = r_awvalid & i_awready;
   assign w_w_hs       = r_wvalid & i_wready;
   assign w_b_hs       = r_bready & i_bvalid;
   assign w_last_burst = (r_burst == LAST_BURST);

`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
   assign o_arid    = INIT_ID;
   assign o_araddr  = r_addr;
   assign o_arlen   = AXLEN;
   assign o_arsize  = AXI_SIZE_8B;
   assign o_arburst = AXI_BURST_INCR;
   assign o_arvalid = r_arvalid;
   assign o_rready  = r_rready;
   assign w_ar_hs   = r_arvalid & i_arready;
   assign w_r_hs    = r_rready & i_rvalid;
   assign w_beat_adv = w_w_hs | w_r_hs;
   assign w_rd_end   = w_r_hs & w_last;
`else
   assign w_beat_adv = w_w_hs;
   assign w_rd_end   = 1'b0;
`endif

   veerwolf_ram_init_beatcnt #(
      .BURST_LEN (BURST_LEN)
   ) u_beatcnt (
      .clk    (clk),
      .rst    (rst),
      .i_adv  (w_beat_adv),
      .o_last (w_last)
   );

   // Error events: bad write response, or (verify build) bad read beat
   always_comb begin
      w_err_evt = 1'b0;
      if (w_b_hs && ((i_bresp != AXI_RESP_OKAY) || (i_bid != INIT_ID))) begin
         w_err_evt = 1'b1;
      end else begin
         w_err_evt = 1'b0;
      end
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
      if (w_r_hs && ((i_rdata != FILL_VALUE) || (i_rresp != AXI_RESP_OKAY) ||
                     (i_rid != INIT_ID) || (i_rlast != w_last))) begin
         w_err_evt = 1'b1;
      end else begin
         w_err_evt = w_err_evt;
      end
`endif
   end

   // Next-state decode: one outstanding burst, AW -> W -> B per burst
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_AW: begin
            if (w_aw_hs) begin
               w_state_nxt = ST_W;
            end else begin
               w_state_nxt = ST_AW;
            end
         end
         ST_W: begin
            if (w_w_hs && w_last) begin
               w_state_nxt = ST_B;
            end else begin
               w_state_nxt = ST_W;
            end
         end
         ST_B: begin
            if (w_b_hs) begin
               if (w_last_burst) begin
                  w_state_nxt = ST_AFTER_WR;
               end else begin
                  w_state_nxt = ST_AW;
               end
            end else begin
               w_state_nxt = ST_B;
            end
         end
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
         ST_RA: begin
            if (w_ar_hs) begin
               w_state_nxt = ST_R;
            end else begin
               w_state_nxt = ST_RA;
            end
         end
         ST_R: begin
            if (w_rd_end) begin
               if (w_last_burst) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_RA;
               end
            end else begin
               w_state_nxt = ST_R;
            end
         end
`else
         // Read states are unreachable without verification; park safely
         ST_RA, ST_R: w_state_nxt = ST_DONE;
`endif
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_AW;
      endcase
   end

   // State, registered channel valids/readies, address and burst tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_AW;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_addr    <= {ADDR_WIDTH{1'b0}};
         r_burst   <= {BW{1'b0}};
         r_done    <= 1'b0;
         r_error   <= 1'b0;
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         // Valids are registered from the next state so they rise with it
         r_awvalid <= (w_state_nxt == ST_AW);
         r_wvalid  <= (w_state_nxt == ST_W);
         r_bready  <= (w_state_nxt == ST_B);
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
         r_arvalid <= (w_state_nxt == ST_RA);
         r_rready  <= (w_state_nxt == ST_R);
`endif
         if (w_b_hs || w_rd_end) begin
            if (w_last_burst) begin
               // Read-back (if any) restarts from the bottom of the RAM
               r_burst <= {BW{1'b0}};
`ifdef VEERWOLF_RAM_INIT_VERIFY_EN
               r_addr  <= {ADDR_WIDTH{1'b0}};
`else
               r_addr  <= r_addr + BURST_BYTES;
`endif
            end else begin
               r_burst <= r_burst + BURST_ONE;
               r_addr  <= r_addr + BURST_BYTES;
            end
         end else begin
            r_burst <= r_burst;
            r_addr  <= r_addr;
         end
         r_error <= r_error | w_err_evt;
         r_done  <= r_done | (w_state_nxt == ST_DONE);
      end
   end

endmodule
